// File: rtl/dice_disp_sched.sv
// Display sequencer for the dice game: blank / rolling animation / rotating die1, die2, sum.
// Optional macro DICE_DBL_FLASH_EN flashes the display (disp_blank toggling) while showing doubles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | after reset, display blanked
// ROLL     | roll button held, animation 1..6 stepping every ANIM_DIV clk
// WAIT     | button released, animation frozen, waiting for a legal result
// SHOW_D1  | showing latched die1 for DWELL clk
// SHOW_D2  | showing latched die2 for DWELL clk
// SHOW_SUM | showing die1+die2 for DWELL clk, then back to SHOW_D1
module dice_disp_sched #(
    parameter int DWELL    = 50000000,
    parameter int ANIM_DIV = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll_req,
    input  logic       result_vld,
    input  logic [2:0] die1,
    input  logic [2:0] die2,
    output logic [3:0] disp_num,
    output logic       disp_blank,
    output logic [1:0] disp_src,
    output logic       busy
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DW-1:0] DWELL_TC = DW'(DWELL - 1);
    localparam logic [AW-1:0] ANIM_TC  = AW'(ANIM_DIV - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROLL     = 3'd1,
        WAIT     = 3'd2,
        SHOW_D1  = 3'd3,
        SHOW_D2  = 3'd4,
        SHOW_SUM = 3'd5
    } state_t;

    state_t        state;
    logic [2:0]    d1;
    logic [2:0]    d2;
    logic [3:0]    sum;
    logic [AW-1:0] anim_cnt;
    logic [DW-1:0] dwell_cnt;
    logic          dice_ok;

    assign dice_ok = (die1 != 3'd0) && (die1 != 3'd7) && (die2 != 3'd0) && (die2 != 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            d1         <= '0;
            d2         <= '0;
            sum        <= '0;
            anim_cnt   <= '0;
            dwell_cnt  <= '0;
            disp_num   <= '0;
            disp_blank <= 1'b1;
            disp_src   <= 2'b00;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    disp_num   <= '0;
                    disp_blank <= 1'b1;
                    disp_src   <= 2'b00;
                    busy       <= 1'b0;
                    if (roll_req) begin
                        state      <= ROLL;
                        anim_cnt   <= '0;
                        dwell_cnt  <= '0;
                        disp_num   <= 4'd1;
                        disp_blank <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                ROLL: begin
                    if (!roll_req) begin
                        state <= WAIT;
                    end else if (anim_cnt == ANIM_TC) begin
                        anim_cnt <= '0;
                        disp_num <= (disp_num == 4'd6) ? 4'd1 : disp_num + 4'd1;
                    end else begin
                        anim_cnt <= anim_cnt + 1'b1;
                    end
                end

                WAIT: begin
                    if (roll_req) begin
                        // roll_req has priority over a result arriving in the same cycle
                        state      <= ROLL;
                        anim_cnt   <= '0;
                        dwell_cnt  <= '0;
                        disp_num   <= 4'd1;
                        disp_blank <= 1'b0;
                        disp_src   <= 2'b00;
                        busy       <= 1'b1;
                    end else if (result_vld && dice_ok) begin
                        state      <= SHOW_D1;
                        d1         <= die1;
                        d2         <= die2;
                        sum        <= {1'b0, die1} + {1'b0, die2};
                        anim_cnt   <= '0;
                        dwell_cnt  <= '0;
                        disp_num   <= {1'b0, die1};
                        disp_blank <= 1'b0;
                        disp_src   <= 2'b01;
                        busy       <= 1'b0;
                    end
                end

                SHOW_D1, SHOW_D2, SHOW_SUM: begin
                    if (roll_req) begin
                        state      <= ROLL;
                        anim_cnt   <= '0;
                        dwell_cnt  <= '0;
                        disp_num   <= 4'd1;
                        disp_blank <= 1'b0;
                        disp_src   <= 2'b00;
                        busy       <= 1'b1;
                    end else begin
                        if (dwell_cnt == DWELL_TC) begin
                            dwell_cnt <= '0;
                            case (state)
                                SHOW_D1: begin
                                    state    <= SHOW_D2;
                                    disp_num <= {1'b0, d2};
                                    disp_src <= 2'b10;
                                end
                                SHOW_D2: begin
                                    state    <= SHOW_SUM;
                                    disp_num <= sum;
                                    disp_src <= 2'b11;
                                end
                                default: begin
                                    state    <= SHOW_D1;
                                    disp_num <= {1'b0, d1};
                                    disp_src <= 2'b01;
                                end
                            endcase
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
`ifdef DICE_DBL_FLASH_EN
                        // doubles flash; the phase carries across D1/D2/SUM rotation
                        if (anim_cnt == ANIM_TC) begin
                            anim_cnt <= '0;
                            if (d1 == d2) disp_blank <= ~disp_blank;
                        end else begin
                            anim_cnt <= anim_cnt + 1'b1;
                        end
`endif
                    end
                end

                default: begin
                    state      <= IDLE;
                    anim_cnt   <= '0;
                    dwell_cnt  <= '0;
                    disp_num   <= '0;
                    disp_blank <= 1'b1;
                    disp_src   <= 2'b00;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dice_disp_sched.sv
// Scoreboard bench for dice_disp_sched: directed scenarios followed by random roll/result traffic.
module tb_dice_disp_sched;

    localparam int DWELL    = 4;
    localparam int ANIM_DIV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       roll_req = 1'b0;
    logic       result_vld = 1'b0;
    logic [2:0] die1 = 3'd0;
    logic [2:0] die2 = 3'd0;
    logic [3:0] disp_num;
    logic       disp_blank;
    logic [1:0] disp_src;
    logic       busy;

    dice_disp_sched #(.DWELL(DWELL), .ANIM_DIV(ANIM_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .roll_req(roll_req), .result_vld(result_vld),
        .die1(die1), .die2(die2), .disp_num(disp_num), .disp_blank(disp_blank),
        .disp_src(disp_src), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] num;
        logic       blank;
        logic [1:0] src;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: mode 0 idle, 1 roll, 2 wait, 3 show
    int   mode = 0;
    int   n = 0;
    int   m = 0;
    int   frozen = 0;
    int   sv[3];

    function automatic int roll_val(input int k);
        return (k / ANIM_DIV) % 6 + 1;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   idx;
        e = '{num: 4'd0, blank: 1'b1, src: 2'b00, busy: 1'b0};
        case (mode)
            1: e = '{num: 4'(roll_val(n)), blank: 1'b0, src: 2'b00, busy: 1'b1};
            2: e = '{num: 4'(frozen), blank: 1'b0, src: 2'b00, busy: 1'b1};
            3: begin
                idx = (m / DWELL) % 3;
                e.num   = 4'(sv[idx]);
                e.src   = 2'(idx + 1);
                e.busy  = 1'b0;
                e.blank = 1'b0;
`ifdef DICE_DBL_FLASH_EN
                if (sv[0] == sv[1]) e.blank = 1'((m / ANIM_DIV) % 2);
`endif
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_step(input logic r, input logic v, input int a, input int b);
        case (mode)
            0: if (r) begin mode = 1; n = 0; end
            1: if (!r) begin mode = 2; frozen = roll_val(n); end else n++;
            2: begin
                if (r) begin
                    mode = 1; n = 0;
                end else if (v && a >= 1 && a <= 6 && b >= 1 && b <= 6) begin
                    mode = 3; m = 0;
                    sv[0] = a; sv[1] = b; sv[2] = a + b;
                end
            end
            default: if (r) begin mode = 1; n = 0; end else m++;
        endcase
    endtask

    task automatic cyc(input logic r, input logic v, input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        roll_req = r; result_vld = v; die1 = a; die2 = b;
        @(posedge clk);
        if (rst_n) model_step(r, v, int'(a), int'(b));
        q.push_back(model_out());
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic hold_roll(input int k);
        for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 3'd0, 3'd0);
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        rst_n = 1'b0;
        mode = 0;
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 3'd0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: every clock the DUT presents a registered output word
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (disp_num !== e.num || disp_blank !== e.blank || disp_src !== e.src || busy !== e.busy) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got num=%0d blank=%0b src=%0b busy=%0b, want num=%0d blank=%0b src=%0b busy=%0b",
                             $time, disp_num, disp_blank, disp_src, busy, e.num, e.blank, e.src, e.busy);
                end
            end
        end
    end

    initial begin
        logic r;
        logic v;
        do_reset(3);
        idle(20);

        hold_roll(14);
        idle(3);
        cyc(1'b0, 1'b1, 3'd3, 3'd5);
        idle(16);

        hold_roll(3);
        idle(2);
        cyc(1'b0, 1'b1, 3'd0, 3'd4);
        idle(2);
        cyc(1'b0, 1'b1, 3'd7, 3'd2);
        idle(1);
        cyc(1'b0, 1'b1, 3'd6, 3'd6);
        idle(13);

        hold_roll(2);
        idle(1);
        cyc(1'b0, 1'b1, 3'd2, 3'd4);
        idle(5);
        hold_roll(3);
        idle(2);
        cyc(1'b1, 1'b1, 3'd1, 3'd1);
        idle(3);
        cyc(1'b0, 1'b1, 3'd2, 3'd2);
        idle(14);
        cyc(1'b0, 1'b1, 3'd5, 3'd5);

        do_reset(2);
        idle(3);

        r = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) r = ~r;
            v = ($urandom_range(0, 3) == 0);
            cyc(r, v, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected words left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
